tx_credit_ctrl: RTL
===================

// Module: tx_credit_ctrl
// PURPOSE
//  Transmit-side flow control for the Aurora link, the far end of the receiver hold buffer.
//  - The remote receiver advertises its free hold-buffer slots (empty_slots, 18 b).
//  - This block tracks those credits and reads words from the local source FIFO.
//  - It drives them onto the Aurora TX LocalLink only while credit remains, so the remote buffer never overflows.
//  - Sits between the local TX data FIFO and the Aurora TX LocalLink; credit values arrive from the Aurora RX status path.
// PARAMETERS
//  DW        32    data word width
//  CW        18    credit / empty-slot count width
//  MARGIN    8     slots withheld from each advertised value (covers words in flight during the round trip)
//  STALE_CYC 4096  cycles without a credit update, while in RUN, before credits are revoked
// PORTS
//  clk_i           in   1   single clock for all logic
//  reset_n_i       in   1   asynchronous, active-low reset
//  channel_up_i    in   1   Aurora channel up
//  fifo_dat_i      in   DW  source FIFO read data; valid 1 cycle after fifo_rd_o
//  fifo_empty_i    in   1   source FIFO empty
//  fifo_rd_o       out  1   source FIFO read enable
//  credit_upd_i    in   1   1-cycle strobe: credit_val_i holds a fresh remote empty_slots snapshot
//  credit_val_i    in   CW  remote free-slot count
//  tx_d_o          out  DW  LocalLink TX data
//  tx_src_rdy_n_o  out  1   LocalLink source ready (active low)
//  tx_dst_rdy_n_i  in   1   LocalLink destination ready (active low)
//  credit_o        out  CW  current credit count
//  stale_o         out  1   1 while in STALE
//  tx_word_cnt_o   out  32  words transferred on LocalLink; wraps 0xFFFFFFFF -> 0
// BEHAVIOUR
//  Reset values (reset_n_i=0, async):
//   - fifo_rd_o=0, tx_src_rdy_n_o=1, tx_d_o=0, credit_o=0, stale_o=0, tx_word_cnt_o=0
//   - buffer empty, stale timer 0, state=WAIT
//  States:
//   - WAIT (credit 0, no reads) -> RUN on credit_upd_i & channel_up_i
//   - RUN -> STALE when stale timer == STALE_CYC-1; timer cleared on every credit_upd_i
//   - STALE: credit forced to 0, no reads -> RUN on credit_upd_i
//   - any state -> WAIT whenever channel_up_i=0; credit cleared, stale timer cleared
//  Credit load (on credit_upd_i in RUN or STALE; in WAIT only when channel_up_i=1):
//   - credit_o <= (credit_val_i > MARGIN+rd) ? credit_val_i-MARGIN-rd : 0, where rd = fifo_rd_o in the same cycle
//   - a load overrides the plain decrement
//  Otherwise credit_o decrements by 1 on each fifo_rd_o; the credit>0 gate makes underflow impossible.
//  Credit is consumed at FIFO read, not at LocalLink transfer, so words already fetched are pre-paid.
//  Buffer: 2 entries (output register plus skid), counting pending reads.
//   - fifo_rd_o = RUN & channel_up_i & credit_o!=0 & ~fifo_empty_i & (occupancy + pending) < 2, with drain this cycle counted as freeing a slot
//   - read data is captured 1 cycle after fifo_rd_o; sustains 1 word/cycle when dst ready
//  LocalLink:
//   - transfer when ~tx_src_rdy_n_o & ~tx_dst_rdy_n_i
//   - tx_src_rdy_n_o=0 iff output entry valid & channel_up_i
//   - tx_d_o stable while src ready and not accepted; words leave in FIFO order
//   - tx_word_cnt_o increments per transfer
//  Channel drop mid-stream: buffered words are retained; tx_src_rdy_n_o=1 until channel_up_i returns, then they are sent without new credit.
//   - An in-flight read completing during the drop is still captured.
//  WAIT/STALE: buffered words still drain on LocalLink; only new FIFO reads stop.
// TESTING
//  1) credit_upd_i with credit_val_i=20, FIFO holds 50, dst always ready
//     -> exactly 12 fifo_rd_o pulses, 12 transfers, credit_o=0.
//  2) Back-to-back stream with credit 100
//     -> after 2-cycle fill, tx_src_rdy_n_o=0 every cycle; tx_d_o matches FIFO order.
//  3) Hold tx_dst_rdy_n_i=1 for 10 cycles mid-burst
//     -> at most 2 extra reads, tx_d_o held constant, no word lost or duplicated.
//  4) credit_upd_i (val=30) in the same cycle as fifo_rd_o
//     -> credit_o=21 next cycle; with val=5 -> credit_o=0.
//  5) No update for STALE_CYC=64 cycles in RUN
//     -> stale_o=1 and credit_o=0 at cycle 64; next credit_upd_i (val=40) -> stale_o=0, credit_o=32.
//  6) Drop channel_up_i with 2 words buffered
//     -> src_rdy_n=1, credit_o=0, state WAIT; restore channel -> both words sent, no reads until next update.

Source files
------------

// File: rtl/tx_credit_ctrl.sv
// Credit-gated transmit control: reads the local TX FIFO only while remote hold-buffer credit
// remains, and streams the fetched words onto the Aurora TX LocalLink through a 2-entry buffer.
module tx_credit_ctrl #(
   parameter int DW        = 32,
   parameter int CW        = 18,
   parameter int MARGIN    = 8,
   parameter int STALE_CYC = 4096
) (
   input  logic          clk_i,
   input  logic          reset_n_i,
   input  logic          channel_up_i,
   input  logic [DW-1:0] fifo_dat_i,
   input  logic          fifo_empty_i,
   output logic          fifo_rd_o,
   input  logic          credit_upd_i,
   input  logic [CW-1:0] credit_val_i,
   output logic [DW-1:0] tx_d_o,
   output logic          tx_src_rdy_n_o,
   input  logic          tx_dst_rdy_n_i,
   output logic [CW-1:0] credit_o,
   output logic          stale_o,
   output logic [31:0]   tx_word_cnt_o
);

   localparam int TW  = (STALE_CYC > 1) ? $clog2(STALE_CYC) : 1;
   localparam int CW1 = CW + 1;

   typedef enum logic [1:0] {
      ST_WAIT,
      ST_RUN,
      ST_STALE
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   credit, credit_nxt;
   logic [TW-1:0]   timer, timer_nxt;

   logic            rd;
   logic            rd_vld_p1;
   logic            out_vld, skid_vld;
   logic [DW-1:0]   out_dat, skid_dat;
   logic [31:0]     word_cnt;
   logic            drain;
   logic [1:0]      fill;

   // Advertised slots minus the in-flight margin and a read consumed in the same cycle, floored at 0.
   function automatic logic [CW-1:0] sat_load(input logic [CW-1:0] val, input logic rd_now);
      logic [CW:0] ded;
      logic [CW:0] diff;
      ded  = CW1'(MARGIN) + CW1'(rd_now);
      diff = CW1'(val) - ded;
      if (CW1'(val) > ded) sat_load = diff[CW-1:0];
      else                 sat_load = '0;
   endfunction

   assign drain = out_vld & channel_up_i & ~tx_dst_rdy_n_i;
   assign fill  = 2'(out_vld) + 2'(skid_vld) + 2'(rd_vld_p1) - 2'(drain);
   assign rd    = (state == ST_RUN) & channel_up_i & (credit != '0) & ~fifo_empty_i & (fill < 2'd2);

   always_comb begin
      state_nxt  = state;
      credit_nxt = credit;
      timer_nxt  = timer;
      if (!channel_up_i) begin
         state_nxt  = ST_WAIT;
         credit_nxt = '0;
         timer_nxt  = '0;
      end else if (credit_upd_i) begin
         state_nxt  = ST_RUN;
         credit_nxt = sat_load(credit_val_i, rd);
         timer_nxt  = '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (timer == TW'(STALE_CYC - 1)) begin
                  state_nxt  = ST_STALE;
                  credit_nxt = '0;
                  timer_nxt  = '0;
               end else begin
                  timer_nxt  = timer + 1'b1;
                  credit_nxt = credit - CW'(rd);
               end
            end
            ST_STALE: credit_nxt = '0;
            ST_WAIT:  credit_nxt = '0;
            default: begin
               state_nxt  = ST_WAIT;
               credit_nxt = '0;
               timer_nxt  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state  <= ST_WAIT;
         credit <= '0;
         timer  <= '0;
      end else begin
         state  <= state_nxt;
         credit <= credit_nxt;
         timer  <= timer_nxt;
      end
   end

   // Stage p1: FIFO data for the previous read is on fifo_dat_i; shift it into out/skid.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rd_vld_p1 <= 1'b0;
         out_vld   <= 1'b0;
         skid_vld  <= 1'b0;
         out_dat   <= '0;
         word_cnt  <= '0;
      end else begin
         rd_vld_p1 <= rd;
         if (drain) begin
            word_cnt <= word_cnt + 32'd1;
            if (skid_vld) begin
               out_dat  <= skid_dat;
               skid_vld <= rd_vld_p1;
            end else begin
               out_vld <= rd_vld_p1;
               if (rd_vld_p1) out_dat <= fifo_dat_i;
            end
         end else if (rd_vld_p1) begin
            if (!out_vld) begin
               out_vld <= 1'b1;
               out_dat <= fifo_dat_i;
            end else begin
               skid_vld <= 1'b1;
            end
         end
      end
   end

   // Skid data only ever loads behind a valid output entry; it needs no reset.
   always_ff @(posedge clk_i) begin
      if (rd_vld_p1 && out_vld && (!drain || skid_vld)) skid_dat <= fifo_dat_i;
   end

   assign fifo_rd_o      = rd;
   assign tx_d_o         = out_dat;
   assign tx_src_rdy_n_o = ~(out_vld & channel_up_i);
   assign credit_o       = credit;
   assign stale_o        = (state == ST_STALE);
   assign tx_word_cnt_o  = word_cnt;

   a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      (rd_vld_p1 && out_vld && skid_vld) |-> drain);
   a_hold_data: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      (out_vld && !drain) |=> $stable(out_dat));

endmodule
